// File: rtl/fpu_pkg.sv
// Shared definitions for the parameterised FP multiplier: FSM encoding, flag
// bit positions and field-width helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_ROUND  = 3'd4,
    S_DONE   = 3'd5
  } fpu_state_e;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;

  function automatic int fpu_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all-ones, only the fraction MSB set.
  function automatic logic [63:0] fpu_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even on a normalised mantissa with guard/round/sticky;
// renormalises on carry-out by bumping the exponent.
module fpu_round_rne #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]         man_i,
  input  logic                   guard_i,
  input  logic                   round_i,
  input  logic                   sticky_i,
  input  logic signed [EXP_W+1:0] exp_i,
  output logic [MAN_W:0]         man_o,
  output logic signed [EXP_W+1:0] exp_o,
  output logic                   inexact_o
);

  logic             inc;
  logic [MAN_W+1:0] sum;

  assign inc       = guard_i & (round_i | sticky_i | man_i[0]);
  assign sum       = {1'b0, man_i} + {{(MAN_W + 1){1'b0}}, inc};
  assign inexact_o = guard_i | round_i | sticky_i;

  // A carry out leaves 10...0, so the right shift loses nothing.
  always_comb begin
    man_o = sum[MAN_W:0];
    exp_o = exp_i;
    if (sum[MAN_W+1]) begin
      man_o = sum[MAN_W+1:1];
      exp_o = exp_i + (EXP_W + 2)'(1);
    end
  end

endmodule

// File: rtl/fpu_mult_param.sv
// Multi-cycle IEEE-754 multiplier, generic exponent/fraction widths, RNE,
// flush-to-zero on subnormals, valid/ready on both sides.
module fpu_mult_param
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FW    = EXP_W + MAN_W + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] a_in,
  input  logic [FW-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] result,
  output logic [3:0]    flags
);

  localparam int EW2 = EXP_W + 2;
  localparam int MW1 = MAN_W + 1;
  localparam int PW  = 2 * MW1;

  localparam logic signed [EW2-1:0] BIAS_E = EW2'(fpu_bias(EXP_W));
  localparam logic signed [EW2-1:0] EMAX   = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO  = '0;
  localparam logic signed [EW2-1:0] EONE   = EW2'(1);
  localparam logic [63:0]           QNAN64 = fpu_qnan(EXP_W, MAN_W);
  localparam logic [FW-1:0]         QNAN   = QNAN64[FW-1:0];
  localparam logic [PW-1:0]         SMASK  = {PW{1'b1}} >> (PW - MAN_W + 1);

  fpu_state_e            state_q;
  logic                  in_ready_q, out_valid_q;
  logic [FW-1:0]         result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic [FW-1:0]         a_q, b_q;
  logic                  sign_q, invalid_q, inf_q, zero_q;
  logic signed [EW2-1:0] e_q;
  logic [MW1-1:0]        ma_q, mb_q, man_q;
  logic [PW-1:0]         prod_q;
  logic                  g_q, r_q, s_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Operand classification (exp==0 is zero regardless of fraction: FTZ)
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic signed [EW2-1:0] e_sum;

  assign ea     = a_q[FW-2 -: EXP_W];
  assign eb     = b_q[FW-2 -: EXP_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == '1) && (fa == '0);
  assign inf_b  = (eb == '1) && (fb == '0);
  assign nan_a  = (ea == '1) && (fa != '0);
  assign nan_b  = (eb == '1) && (fb != '0);
  assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;

  // Normalisation: bring the leading one to the MSB, then split off G/R/S.
  logic [PW-1:0]  pn;
  logic [MW1-1:0] man_n;
  logic           g_n, r_n, s_n;

  assign pn    = prod_q[PW-1] ? prod_q : {prod_q[PW-2:0], 1'b0};
  assign man_n = pn[PW-1 -: MW1];
  assign g_n   = pn[MAN_W];
  assign r_n   = pn[MAN_W-1];
  assign s_n   = |(pn & SMASK);

  logic [MW1-1:0]        man_r;
  logic signed [EW2-1:0] e_r;
  logic                  inex_r;
  logic                  unused_hidden;

  fpu_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .man_i     (man_q),
    .guard_i   (g_q),
    .round_i   (r_q),
    .sticky_i  (s_q),
    .exp_i     (e_q),
    .man_o     (man_r),
    .exp_o     (e_r),
    .inexact_o (inex_r)
  );

  assign unused_hidden = man_r[MAN_W];

  always_comb begin
    result_d = {sign_q, e_r[EXP_W-1:0], man_r[MAN_W-1:0]};
    flags_d  = '0;
    flags_d[FLG_INEXACT] = inex_r;
    if (invalid_q) begin
      result_d = QNAN;
      flags_d  = '0;
      flags_d[FLG_INVALID] = 1'b1;
    end else if (inf_q) begin
      result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = '0;
    end else if (zero_q) begin
      result_d = {sign_q, {(FW - 1){1'b0}}};
      flags_d  = '0;
    end else if (e_r >= EMAX) begin
      result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = '0;
      flags_d[FLG_OVERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]  = 1'b1;
    end else if (e_r <= EZERO) begin
      result_d = {sign_q, {(FW - 1){1'b0}}};
      flags_d  = '0;
      flags_d[FLG_UNDERFLOW] = 1'b1;
      flags_d[FLG_INEXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid && in_ready_q) begin
          a_q        <= a_in;
          b_q        <= b_in;
          in_ready_q <= 1'b0;
          state_q    <= S_UNPACK;
        end
        S_UNPACK: begin
          sign_q    <= a_q[FW-1] ^ b_q[FW-1];
          invalid_q <= nan_a | nan_b | ((inf_a | inf_b) & (zero_a | zero_b));
          inf_q     <= inf_a | inf_b;
          zero_q    <= zero_a | zero_b;
          e_q       <= e_sum;
          ma_q      <= {1'b1, fa};
          mb_q      <= {1'b1, fb};
          state_q   <= S_MULT;
        end
        S_MULT: begin
          prod_q  <= PW'(ma_q) * PW'(mb_q);
          state_q <= S_NORM;
        end
        S_NORM: begin
          man_q   <= man_n;
          g_q     <= g_n;
          r_q     <= r_n;
          s_q     <= s_n;
          e_q     <= prod_q[PW-1] ? e_q + EONE : e_q;
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          result_q    <= result_d;
          flags_q     <= flags_d;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mult_param.sv
// Self-checking bench for fpu_mult_param in single precision: directed plan
// vectors, backpressure, mid-operation reset and randomized operands.
module tb_fpu_mult_param;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a_in, b_in, result;
  logic [3:0]  flags;
  int          checks = 0;
  int          errors = 0;

  fpu_mult_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, then nearest-even by comparing the
  // discarded remainder against one half ulp.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    int ea, eb, e, drop;
    logic s, nan_x, inf_x, zero_x;
    longint unsigned p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    nan_x  = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
    inf_x  = (ea == 255 && a[22:0] == 0) || (eb == 255 && b[22:0] == 0);
    zero_x = (ea == 0) || (eb == 0);
    r = 32'h0; f = 4'h0;
    if (nan_x || (inf_x && zero_x)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (inf_x) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zero_x) begin
      r = {s, 31'h0};
    end else begin
      p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e = ea + eb - 127;
      drop = 23;
      if (p >= (64'd1 << 47)) begin drop = 24; e++; end
      q    = p >> drop;
      rem  = p - (q << drop);
      half = 64'd1 << (drop - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0011;
      end else begin
        r = {s, e[7:0], q[22:0]}; f = {3'b000, rem != 0};
      end
    end
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept_ready", 32'(in_ready), 32'd1);
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] er, input logic [3:0] ef);
    int lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_result"}, result, er);
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int sel = int'($urandom_range(0, 9));
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 40));
      3:       e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  logic [31:0] dir_a [8] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F000000,
                             32'h00800000, 32'h7F800000, 32'hFF800000, 32'h00000001};
  logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h7F000000,
                             32'h00800000, 32'h00000000, 32'h40000000, 32'h40000000};
  logic [31:0] dir_r [8] = '{32'h40400000, 32'hC0C00000, 32'h3FC00002, 32'h7F800000,
                             32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
  logic [3:0]  dir_f [8] = '{4'h0, 4'h0, 4'h1, 4'h5, 4'h3, 4'h8, 4'h0, 4'h0};

  initial begin
    logic [31:0] ra, rb, er;
    logic [3:0]  ef;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);

    // Directed plan vectors with hand-derived expectations
    for (int i = 0; i < 8; i++) begin
      start(dir_a[i], dir_b[i]);
      wait_result($sformatf("dir%0d", i), dir_r[i], dir_f[i]);
      handshake();
    end

    // Backpressure: result held for 10 cycles while out_ready is low
    out_ready = 1'b0;
    model(32'h3F800001, 32'h3FC00000, er, ef);
    start(32'h3F800001, 32'h3FC00000);
    wait_result("bp", er, ef);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", result, er);
      chk("bp_hold_flags", 32'(flags), 32'(ef));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    handshake();

    // Reset while the transaction sits in MULT: it must never complete
    start(32'h3FC00000, 32'h40000000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    start(32'h3FC00000, 32'h40000000);
    wait_result("post_rst", 32'h40400000, 4'h0);
    handshake();

    // Randomized operands against the reference model
    for (int i = 0; i < 150; i++) begin
      ra = rand_op();
      rb = rand_op();
      model(ra, rb, er, ef);
      start(ra, rb);
      wait_result($sformatf("rnd%0d_%h_%h", i, ra, rb), er, ef);
      handshake();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_mult_param.md
Name: fpu_mult_param

Overview:
- Parametrised, multi-cycle IEEE-754 multiplier: generic EXP_W/MAN_W, valid/ready handshake on both sides, round-to-nearest-even.
- Handles special operands: zero, inf, NaN; subnormals are flushed to zero.
- Raises sticky-free per-result exception flags.
- Successor to the single-precision start/ready multiplier; feeds the CNN MAC datapath, one result per transaction.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- FW, EXP_W+MAN_W+1, total word width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a_in  in  FW  operand A {sign, exp, frac}
- b_in  in  FW  operand B
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  downstream accepts result
- result  out  FW  packed product
- flags  out  4  {invalid, overflow, underflow, inexact}, valid with out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0.
- Reset mid-operation aborts the current transaction. Its result is never presented.
- FSM states: IDLE, UNPACK, MULT, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register a_in/b_in -> UNPACK; in_ready drops the next cycle.
- UNPACK:
  - Classify each operand: zero if exp==0 (any fraction, FTZ); inf if exp all-ones and frac==0; NaN if exp all-ones and frac!=0.
  - Sign = sa^sb.
  - Exponent sum e = ea+eb-bias, signed, EXP_W+2 bits.
  - Mantissas = {1,frac}.
  - -> MULT.
- MULT: product = ma*mb, 2*(MAN_W+1) bits -> NORM.
- NORM:
  - If product MSB=1, take the top MAN_W+1 bits from the MSB down and set e=e+1; otherwise start one bit lower.
  - Extract guard bit and round bit; sticky = OR of all remaining bits.
  - -> ROUND.
- ROUND:
  - RNE: increment if guard && (round || sticky || lsb).
  - Mantissa carry-out: shift right 1 and set e=e+1.
  - inexact = guard|round|sticky.
  - Pack the result, set out_valid=1 -> DONE.
- Fixed latency: out_valid rises 4 clocks after the accept edge. Special-operand results follow the same latency (no bypass).
- Result select, in priority order:
  1. Any NaN, or inf*zero -> canonical qNaN (sign 0, exp all-ones, frac MSB=1, rest 0); invalid=1.
  2. Any inf -> signed inf, no flags.
  3. Any zero -> signed zero, no flags.
  4. e >= 2^EXP_W-1 after rounding -> signed inf; overflow=1, inexact=1.
  5. e <= 0 -> signed zero (FTZ); underflow=1, inexact=1.
  6. Otherwise normal packed result with the inexact flag computed in ROUND.
- DONE:
  - result and flags are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: out_valid=0 next cycle, state -> IDLE.
- in_valid while not in IDLE is ignored (in_ready=0); the upstream block must hold its operands.
- Minimum throughput: one transaction per 6 cycles.

Decomposition:
- Package fpu_pkg:
  - state encoding (3-bit localparams)
  - flag bit indices (INEXACT=0, UNDERFLOW=1, OVERFLOW=2, INVALID=3)
  - bias function of EXP_W
  - canonical-qNaN builder function of EXP_W/MAN_W
- Sub-module fpu_round_rne (combinational):
  - inputs: mantissa, guard, round, sticky, exponent
  - outputs: rounded mantissa, adjusted exponent, inexact
  - reused later by the adder.

Test Plan (defaults, single precision):
- 0x3FC00000 * 0x40000000 (1.5*2.0) -> result 0x40400000, flags 0; out_valid exactly 4 clocks after accept.
- 0xC0000000 * 0x40400000 (-2*3) -> 0xC0C00000, flags 0. Then 0x3F800001 * 0x3FC00000 (RNE tie) -> 0x3FC00002, inexact=1.
- 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1, inexact=1. 0x00800000 * 0x00800000 -> 0x00000000, underflow=1, inexact=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1. 0xFF800000 * 0x40000000 -> 0xFF800000, flags 0. 0x00000001 * 0x40000000 -> 0x00000000, flags 0 (FTZ input).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable and in_ready=0 throughout. Then out_ready=1 for 1 cycle -> IDLE, in_ready=1 the next cycle.
- Assert rst_n=0 for 1 cycle while in MULT -> out_valid stays 0, in_ready=1 after reset. The next transaction 0x3FC00000*0x40000000 completes correctly.
